fpu_sign_pipe: RTL and testbench
================================

Name: fpu_sign_pipe

Overview:
- Pipelined, multi-lane successor of the add/sub sign stage; resolves result sign for add, sub, mul and div in parallel with the mantissa datapath.
- Takes per-lane operand signs, opcode and exponent/mantissa compare flags. Produces the final sign and effective-operation bit two cycles later.
- Uses a valid/ready handshake so it can stall in lockstep with the FPU pipeline.
- Adds two rules: IEEE exact-cancellation zero sign, which depends on rounding mode, and a flush.

Parameters:
- LANES, 1, number of independent sign lanes processed per transaction.
- TAG_W, 4, width of the opaque tag carried alongside each transaction.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- RstN  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous clear of both pipeline stages.
- InValid  in  1  input transaction valid.
- InReady  out  1  stage A can accept.
- Op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div; shared by all lanes.
- RoundMode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- InTag  in  TAG_W  passthrough tag.
- SignX  in  LANES  sign of operand X, per lane.
- SignY  in  LANES  sign of operand Y, per lane.
- ExpYGt  in  LANES  1 when Ey > Ex.
- ExpEq  in  LANES  1 when Ex == Ey.
- ManYGt  in  LANES  1 when My > Mx.
- ManEq  in  LANES  1 when Mx == My.
- OutValid  out  1  output transaction valid.
- OutReady  in  1  downstream accepts.
- OutTag  out  TAG_W  tag of the output transaction.
- ResSign  out  LANES  final result sign per lane.
- EffSub  out  LANES  1 when the effective operation is a magnitude subtract (add/sub only; 0 for mul/div).

Behaviour:
- Reset (RstN=0, async): stage-A valid=0, stage-B valid=0, OutValid=0, ResSign=0, EffSub=0, OutTag=0; InReady=1 once reset is released.
- Two registered stages, A and B.
- Latency is exactly 2 cycles from input handshake to OutValid when no stall; throughput is 1 per cycle.
- Handshake:
  - Input transfer occurs when InValid & InReady.
  - Output transfer occurs when OutValid & OutReady.
  - B advance = ~BValid | OutReady.
  - A advance = ~AValid | B advance.
  - InReady = A advance (combinational, no dependency on InValid).
  - A stalled stage holds its data unchanged.
  - Outputs are stable while OutValid & ~OutReady.
- Stage A, per lane i, registered:
  - xs = SignX^SignY
  - eff = ~Op[1] & (Op[0]^xs)
  - ylarger = ExpYGt | (ExpEq & ManYGt)
  - cancel = eff & ExpEq & ManEq
  - Captured together with Op, RoundMode and tag.
- Stage B, per lane, registered:
  - Op[1]=1 (mul/div): sign = xs.
  - Op[1]=0 and ~eff: sign = SignX.
  - eff and cancel: sign = (RoundMode==010).
  - eff and ~cancel: sign = ylarger ? (SignY^Op[0]) : SignX.
  - EffSub = eff.
- Lanes are fully independent; Op, RoundMode and tag are shared.
- Flush: on the next edge AValid=0 and BValid=0.
  - Flush takes priority over simultaneous input or output transfer; a concurrent output handshake is treated as completed.
  - InReady is unaffected by Flush.
- Invalid RoundMode codes (101–111) are treated as RNE.
- Reset asserted mid-stream discards all in-flight transactions immediately.

Optional Feature:
- Macro FPU_SIGN_NAN_EN.
- When defined, adds inputs NaNX [LANES] and NaNY [LANES] and output ResNaN [LANES], registered through both stages.
  - Lane NaN (NaNX|NaNY) forces ResSign=0 (canonical qNaN) and ResNaN=1.
  - Invalid-op eff-sub of equal infinities is detected upstream and fed in as NaN.
- When undefined, these ports do not exist and the sign is computed as above regardless of NaN operands.

Test Plan:
- Add, SignX=0, SignY=1, Op=00, ExpYGt=1 -> after 2 cycles: EffSub=1, ResSign=1.
- Sub, SignX=0, SignY=0, ExpEq=1, ManEq=1:
  - RoundMode=010 -> ResSign=1.
  - RoundMode=000 -> ResSign=0.
- Mul, SignX=1, SignY=1, Op=10 -> ResSign=0, EffSub=0; div with signs 1/0 -> ResSign=1.
- LANES=4, back-to-back 8 transactions, OutReady toggling 1,0,0,1… -> no loss or duplication, tags 0..7 in order, InReady low only when both stages are full and stalled.
- Flush with both stages valid and OutReady=0 -> OutValid=0 next cycle, next input emerges 2 cycles after acceptance.
- RstN pulsed low mid-stream (async, between edges) -> OutValid and ResSign 0 immediately; with FPU_SIGN_NAN_EN, NaNX=1 on lane 0 -> ResNaN=1, ResSign=0.

Source files
------------

// File: rtl/fpu_sign_pipe.sv
// fpu_sign_pipe: two-stage, multi-lane result-sign resolver for add/sub/mul/div with valid/ready flow control.
// Optional NaN propagation (NaN inputs, ResNaN output) is enabled by defining FPU_SIGN_NAN_EN.

module fpu_sign_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_en_i,
  input  logic       b_en_i,
  input  logic [1:0] op_i,
  input  logic [1:0] op_a_i,
  input  logic [2:0] rm_a_i,
  input  logic       sign_x_i,
  input  logic       sign_y_i,
  input  logic       exp_y_gt_i,
  input  logic       exp_eq_i,
  input  logic       man_y_gt_i,
  input  logic       man_eq_i,
`ifdef FPU_SIGN_NAN_EN
  input  logic       nan_x_i,
  input  logic       nan_y_i,
  output logic       res_nan_o,
`endif
  output logic       res_sign_o,
  output logic       eff_sub_o
);

  typedef struct packed {
    logic xs;
    logic eff;
    logic ylarger;
    logic cancel;
    logic sx;
    logic sy;
`ifdef FPU_SIGN_NAN_EN
    logic nan;
`endif
  } lane_a_t;

  lane_a_t a_d, a_q;
  logic    sign_d, sign_q, eff_q;

  always_comb begin
    a_d         = '0;
    a_d.xs      = sign_x_i ^ sign_y_i;
    a_d.eff     = ~op_i[1] & (op_i[0] ^ a_d.xs);
    a_d.ylarger = exp_y_gt_i | (exp_eq_i & man_y_gt_i);
    a_d.cancel  = a_d.eff & exp_eq_i & man_eq_i;
    a_d.sx      = sign_x_i;
    a_d.sy      = sign_y_i;
`ifdef FPU_SIGN_NAN_EN
    a_d.nan     = nan_x_i | nan_y_i;
`endif
  end

  // Exact cancellation gives -0 only when rounding down; every other code (incl. illegal ones) gives +0.
  always_comb begin
    sign_d = a_q.sx;
    if (op_a_i[1])
      sign_d = a_q.xs;
    else if (a_q.eff)
      sign_d = a_q.cancel  ? (rm_a_i == 3'b010) :
               a_q.ylarger ? (a_q.sy ^ op_a_i[0]) : a_q.sx;
`ifdef FPU_SIGN_NAN_EN
    if (a_q.nan) sign_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      a_q <= '0;
    else if (a_en_i) a_q <= a_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      eff_q  <= 1'b0;
    end else if (b_en_i) begin
      sign_q <= sign_d;
      eff_q  <= a_q.eff;
    end
  end

`ifdef FPU_SIGN_NAN_EN
  logic nan_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      nan_q <= 1'b0;
    else if (b_en_i) nan_q <= a_q.nan;
  end
  assign res_nan_o = nan_q;
`endif

  assign res_sign_o = sign_q;
  assign eff_sub_o  = eff_q;

endmodule

module fpu_sign_pipe #(
  parameter int LANES = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [2:0]       round_mode_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic [LANES-1:0] sign_x_i,
  input  logic [LANES-1:0] sign_y_i,
  input  logic [LANES-1:0] exp_y_gt_i,
  input  logic [LANES-1:0] exp_eq_i,
  input  logic [LANES-1:0] man_y_gt_i,
  input  logic [LANES-1:0] man_eq_i,
`ifdef FPU_SIGN_NAN_EN
  input  logic [LANES-1:0] nan_x_i,
  input  logic [LANES-1:0] nan_y_i,
  output logic [LANES-1:0] res_nan_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [LANES-1:0] res_sign_o,
  output logic [LANES-1:0] eff_sub_o
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [1:0]       op;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic [STAGES:1]  vld_pipe_q;
  logic             a_adv, b_adv, a_en, b_en;
  req_t             req_d, req_a_q;
  logic [TAG_W-1:0] tag_b_q;

  assign b_adv      = ~vld_pipe_q[2] | out_ready_i;
  assign a_adv      = ~vld_pipe_q[1] | b_adv;
  assign in_ready_o = a_adv;

  // Data registers only load on a real transfer; flush blocks the load so it wins over a same-edge handshake.
  assign a_en = in_valid_i & a_adv & ~flush_i;
  assign b_en = vld_pipe_q[1] & b_adv & ~flush_i;

  assign req_d = '{op: op_i, rm: round_mode_i, tag: in_tag_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_pipe_q <= '0;
    else if (flush_i)
      vld_pipe_q <= '0;
    else begin
      if (a_adv) vld_pipe_q[1] <= in_valid_i;
      if (b_adv) vld_pipe_q[2] <= vld_pipe_q[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    req_a_q <= '0;
    else if (a_en) req_a_q <= req_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tag_b_q <= '0;
    else if (b_en) tag_b_q <= req_a_q.tag;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fpu_sign_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_en_i     (a_en),
      .b_en_i     (b_en),
      .op_i       (op_i),
      .op_a_i     (req_a_q.op),
      .rm_a_i     (req_a_q.rm),
      .sign_x_i   (sign_x_i[i]),
      .sign_y_i   (sign_y_i[i]),
      .exp_y_gt_i (exp_y_gt_i[i]),
      .exp_eq_i   (exp_eq_i[i]),
      .man_y_gt_i (man_y_gt_i[i]),
      .man_eq_i   (man_eq_i[i]),
`ifdef FPU_SIGN_NAN_EN
      .nan_x_i    (nan_x_i[i]),
      .nan_y_i    (nan_y_i[i]),
      .res_nan_o  (res_nan_o[i]),
`endif
      .res_sign_o (res_sign_o[i]),
      .eff_sub_o  (eff_sub_o[i])
    );
  end

  assign out_valid_o = vld_pipe_q[2];
  assign out_tag_o   = tag_b_q;

endmodule

// File: tb/tb_fpu_sign_pipe.sv
// Randomized scoreboard bench for fpu_sign_pipe: a magnitude-compare reference model predicts each
// accepted transaction; a negedge monitor pushes on input transfer and pops/compares on output transfer.
module tb_fpu_sign_pipe;
  localparam int L  = 4;
  localparam int TW = 4;

  typedef struct packed {
    logic [1:0]          op;
    logic [2:0]          rm;
    logic [TW-1:0]       tag;
    logic [L-1:0]        sx, sy, nx, ny;
    logic [L-1:0][1:0]   ex, ey, mx, my;
  } stim_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [L-1:0]  sign, eff, nan;
  } exp_t;

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] op;
  logic [2:0] rm;
  logic [TW-1:0] in_tag, out_tag;
  logic [L-1:0] sx, sy, eyg, eeq, myg, meq, res_sign, eff_sub;
  logic [L-1:0] nx, ny;
`ifdef FPU_SIGN_NAN_EN
  logic [L-1:0] res_nan;
`endif

  fpu_sign_pipe #(.LANES(L), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .round_mode_i(rm), .in_tag_i(in_tag),
    .sign_x_i(sx), .sign_y_i(sy), .exp_y_gt_i(eyg), .exp_eq_i(eeq),
    .man_y_gt_i(myg), .man_eq_i(meq),
`ifdef FPU_SIGN_NAN_EN
    .nan_x_i(nx), .nan_y_i(ny), .res_nan_o(res_nan),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
    .res_sign_o(res_sign), .eff_sub_o(eff_sub)
  );

  int total = 0, bad = 0;
  exp_t sbq[$];
  stim_t cur;
  int or_mode = 0;
  bit flush_en = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Signed-magnitude view: values are ex*4+mx; the larger magnitude wins, equal magnitudes give exact zero.
  function automatic exp_t model(stim_t s);
    exp_t r;
    r = '0;
    r.tag = s.tag;
    for (int i = 0; i < L; i++) begin
      int xm, ym;
      logic ys;
      xm = int'(s.ex[i]) * 4 + int'(s.mx[i]);
      ym = int'(s.ey[i]) * 4 + int'(s.my[i]);
      ys = s.sy[i] ^ s.op[0];
      if (s.op[1]) begin
        r.sign[i] = s.sx[i] ^ s.sy[i];
        r.eff[i]  = 1'b0;
      end else if (s.sx[i] == ys) begin
        r.sign[i] = s.sx[i];
        r.eff[i]  = 1'b0;
      end else begin
        r.eff[i] = 1'b1;
        if (ym > xm)       r.sign[i] = ys;
        else if (ym == xm) r.sign[i] = (s.rm == 3'd2);
        else               r.sign[i] = s.sx[i];
      end
`ifdef FPU_SIGN_NAN_EN
      r.nan[i] = s.nx[i] | s.ny[i];
      if (r.nan[i]) r.sign[i] = 1'b0;
`endif
    end
    return r;
  endfunction

  function automatic stim_t mk(input logic [1:0] o, input logic [2:0] m, input logic [TW-1:0] t,
                               input logic a, input logic b, input logic [1:0] xe, input logic [1:0] ye,
                               input logic [1:0] xm, input logic [1:0] ym);
    stim_t s;
    s = '0;
    s.op = o; s.rm = m; s.tag = t;
    s.sx = {L{a}}; s.sy = {L{b}};
    for (int i = 0; i < L; i++) begin
      s.ex[i] = xe; s.ey[i] = ye; s.mx[i] = xm; s.my[i] = ym;
    end
    return s;
  endfunction

  function automatic stim_t rnd(input logic [TW-1:0] t);
    stim_t s;
    s.op = 2'($urandom); s.rm = 3'($urandom_range(0, 7)); s.tag = t;
    s.sx = L'($urandom); s.sy = L'($urandom);
    s.nx = ($urandom_range(0, 3) == 0) ? L'($urandom) : '0;
    s.ny = ($urandom_range(0, 3) == 0) ? L'($urandom) : '0;
    for (int i = 0; i < L; i++) begin
      s.ex[i] = 2'($urandom); s.ey[i] = 2'($urandom);
      s.mx[i] = 2'($urandom); s.my[i] = 2'($urandom);
    end
    return s;
  endfunction

  task automatic apply(input stim_t s);
    op = s.op; rm = s.rm; in_tag = s.tag; sx = s.sx; sy = s.sy; nx = s.nx; ny = s.ny;
    for (int i = 0; i < L; i++) begin
      eyg[i] = s.ey[i] > s.ex[i];
      eeq[i] = s.ey[i] == s.ex[i];
      myg[i] = s.my[i] > s.mx[i];
      meq[i] = s.my[i] == s.mx[i];
    end
    cur = s;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive(input stim_t s);
    int n;
    logic acc;
    n = 0;
    apply(s);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin chk("accept_timeout", 32'(n), 32'(0)); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_check(input stim_t s, input logic [L-1:0] es, input logic [L-1:0] ee,
                            input logic [L-1:0] en);
    drive(s);
    chk("lat1_valid", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat2_valid", 32'(out_valid), 32'(1));
    chk("dir_sign", 32'(res_sign), 32'(es));
    chk("dir_eff", 32'(eff_sub), 32'(ee));
    chk("dir_tag", 32'(out_tag), 32'(s.tag));
`ifdef FPU_SIGN_NAN_EN
    chk("dir_nan", 32'(res_nan), 32'(en));
`else
    if (en != '0) chk("dir_nan_unexpected", 32'(en), 32'(0));
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", 32'(sbq.size()), 32'(0));
  endtask

  initial forever begin
    int pc;
    @(posedge clk); #2;
    case (or_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (pc % 4 == 0) || (pc % 4 == 3); pc++; end
      2: out_ready = 1'($urandom);
      default: out_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(posedge clk); #1;
    if (flush_en) flush = ($urandom_range(0, 39) == 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) sbq.delete();
    else begin
      chk("in_ready", 32'(in_ready), 32'(!(sbq.size() >= 2 && !out_ready)));
      if (sbq.size() == 0) chk("idle_valid", 32'(out_valid), 32'(0));
      else if (out_valid && out_ready) begin
        e = sbq.pop_front();
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
        chk("sb_sign", 32'(res_sign), 32'(e.sign));
        chk("sb_eff", 32'(eff_sub), 32'(e.eff));
`ifdef FPU_SIGN_NAN_EN
        chk("sb_nan", 32'(res_nan), 32'(e.nan));
`endif
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) begin
        if (sbq.size() >= 2) chk("overfill", 32'(sbq.size()), 32'(1));
        sbq.push_back(model(cur));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    apply('0);
    #12;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_sign", 32'(res_sign), 32'(0));
    chk("rst_eff", 32'(eff_sub), 32'(0));
    chk("rst_tag", 32'(out_tag), 32'(0));
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    // Directed sign cases, all lanes identical.
    send_check(mk(2'b00, 3'd0, 4'h1, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0), 4'hF, 4'hF, 4'h0);
    send_check(mk(2'b01, 3'd2, 4'h2, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2, 2'd2), 4'hF, 4'hF, 4'h0);
    send_check(mk(2'b01, 3'd0, 4'h3, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2, 2'd2), 4'h0, 4'hF, 4'h0);
    send_check(mk(2'b01, 3'd5, 4'h4, 1'b1, 1'b1, 2'd2, 2'd2, 2'd1, 2'd1), 4'h0, 4'hF, 4'h0);
    send_check(mk(2'b10, 3'd0, 4'h5, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 2'd1), 4'h0, 4'h0, 4'h0);
    send_check(mk(2'b11, 3'd2, 4'h6, 1'b1, 1'b0, 2'd1, 2'd1, 2'd1, 2'd1), 4'hF, 4'h0, 4'h0);
    send_check(mk(2'b01, 3'd1, 4'h7, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0, 2'd0), 4'hF, 4'h0, 4'h0);
    send_check(mk(2'b00, 3'd3, 4'h8, 1'b1, 1'b0, 2'd2, 2'd2, 2'd0, 2'd3), 4'h0, 4'hF, 4'h0);
    @(posedge clk); #1;

    // Back-to-back tags 0..7 with out_ready pattern 1,0,0,1.
    or_mode = 1;
    for (int i = 0; i < 8; i++) drive(rnd(4'(i)));
    or_mode = 0;
    drain();

    // Flush with both stages full and output stalled.
    or_mode = 3;
    @(posedge clk); #1;
    drive(rnd(4'h9));
    drive(rnd(4'hA));
    chk("pre_flush_valid", 32'(out_valid), 32'(1));
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("post_flush_valid", 32'(out_valid), 32'(0));
    or_mode = 0;
    @(posedge clk); #1;
    send_check(mk(2'b10, 3'd0, 4'hB, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0), 4'hF, 4'h0, 4'h0);
    drain();

    // Random traffic with random backpressure and occasional flush.
    or_mode = 2; flush_en = 1;
    for (int i = 0; i < 300; i++) begin
      drive(rnd(4'(i)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    flush_en = 0; flush = 0; or_mode = 0;
    @(posedge clk); #1;
    drain();

    // Asynchronous reset mid-stream.
    or_mode = 3;
    @(posedge clk); #1;
    drive(mk(2'b00, 3'd0, 4'hC, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0));
    drive(mk(2'b00, 3'd0, 4'hD, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0));
    chk("pre_rst_sign", 32'(res_sign), 32'(4'hF));
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_sign", 32'(res_sign), 32'(0));
    chk("async_rst_tag", 32'(out_tag), 32'(0));
    @(negedge clk); #1 rst_n = 1;
    or_mode = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'(1));
    chk("post_rst_valid", 32'(out_valid), 32'(0));

`ifdef FPU_SIGN_NAN_EN
    s = mk(2'b00, 3'd0, 4'hE, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0);
    s.nx = 4'b0001;
    send_check(s, 4'hE, 4'hF, 4'h1);
`else
    s = '0;
`endif
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
